// File: rtl/pwm_dt_multi.sv
// -----------------------------------------------------------------------------
// pwm_dt_multi
//   Multi-channel PWM generator with double-buffered duty and dead time.
//   One free-running period counter (2^WIDTH clocks) is shared by all channels.
//   Each channel compares the counter against its active duty, then passes the
//   result through a dead-time stage that drives a complementary high/low pair
//   that is never asserted at the same time.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   en            run enable; low holds the counter at 0 and all drives low
//   duty          packed duty values, channel i at [i*WIDTH +: WIDTH]
//   duty_wr       one-cycle strobe capturing all duty fields into the shadow
//   deadtime      dead-time length in clocks, shared by all channels
//   PWM_hi        high-side drive per channel (registered)
//   PWM_lo        low-side drive per channel (registered)
//   period_start  one-cycle pulse in the cnt==0 cycle that follows a wrap
//   duty_upd      one-cycle pulse the cycle after the shadow loads into active
// -----------------------------------------------------------------------------
module pwm_dt_multi #(
    parameter int WIDTH  = 11,
    parameter int NUM_CH = 2,
    parameter int DEAD_W = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_CH*WIDTH-1:0]   duty,
    input  logic                      duty_wr,
    input  logic [DEAD_W-1:0]         deadtime,
    output logic [NUM_CH-1:0]         PWM_hi,
    output logic [NUM_CH-1:0]         PWM_lo,
    output logic                      period_start,
    output logic                      duty_upd
);

    localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [DEAD_W-1:0] DEAD_ONE = DEAD_W'(1);

    logic [WIDTH-1:0]        cnt;
    logic [NUM_CH*WIDTH-1:0] shadow;
    logic [NUM_CH*WIDTH-1:0] active;
    logic                    pending;
    logic [NUM_CH-1:0]       raw_q;
    logic [NUM_CH-1:0]       level;
    logic [DEAD_W-1:0]       dead_cnt [NUM_CH];

    logic wrap;
    logic bypass;
    logic promote;

    // Last count of an enabled period: the only edge at which active may change
    // while running.
    assign wrap    = en && (cnt == CNT_MAX);
    // A write landing exactly on the wrap skips the shadow and goes live at once.
    assign bypass  = wrap && duty_wr;
    // While stopped the shadow is copied through so a later enable starts with
    // the most recently written duty.
    assign promote = pending && (wrap || !en) && !bypass;

    // -------------------------------------------------------------------------
    // Period counter
    // -------------------------------------------------------------------------
    // NOTE: every flop here uses non-blocking assignments so all registers
    // sample pre-edge values and the stages pipeline instead of racing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= en ? cnt + CNT_ONE : '0;
            // Registered from the wrap so no input reaches the pin
            // combinationally; it therefore marks periods that follow a wrap.
            period_start <= wrap;
        end
    end

    // -------------------------------------------------------------------------
    // Double-buffered duty
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow   <= '0;
            active   <= '0;
            pending  <= 1'b0;
            duty_upd <= 1'b0;
        end else begin
            duty_upd <= 1'b0;
            if (duty_wr) begin
                shadow <= duty;
            end
            if (bypass) begin
                active   <= duty;
                pending  <= 1'b0;
                duty_upd <= 1'b1;
            end else if (promote) begin
                active   <= shadow;
                // A write in the same stopped cycle refreshes the shadow, so
                // another copy is still owed on the following edge.
                pending  <= duty_wr;
                duty_upd <= 1'b1;
            end else if (duty_wr) begin
                pending  <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Compare stage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                raw_q[i] <= en && (cnt < active[i*WIDTH +: WIDTH]);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Dead-time stage
    //   level   : last raw value this channel has committed to
    //   dead_cnt: remaining low cycles before the drive for level asserts
    // -------------------------------------------------------------------------
    // NOTE: the dead counters are a handful of flops, not a RAM, so they are
    // reset like any other register; an unreset counter could hold the drives
    // off for an arbitrary time after power-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level  <= '0;
            PWM_hi <= '0;
            PWM_lo <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                dead_cnt[i] <= '0;
            end
        end else if (!en) begin
            level  <= '0;
            PWM_hi <= '0;
            PWM_lo <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                dead_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (raw_q[i] != level[i]) begin
                    // Edge on the compare output: drop both drives and (re)start
                    // the gap toward the new level, even if a gap was running.
                    level[i] <= raw_q[i];
                    if (deadtime == '0) begin
                        dead_cnt[i] <= '0;
                        PWM_hi[i]   <= raw_q[i];
                        PWM_lo[i]   <= !raw_q[i];
                    end else begin
                        dead_cnt[i] <= deadtime;
                        PWM_hi[i]   <= 1'b0;
                        PWM_lo[i]   <= 1'b0;
                    end
                end else if (dead_cnt[i] != '0) begin
                    dead_cnt[i] <= dead_cnt[i] - DEAD_ONE;
                    // The last gap cycle releases the drive on the next edge.
                    PWM_hi[i]   <= (dead_cnt[i] == DEAD_ONE) && level[i];
                    PWM_lo[i]   <= (dead_cnt[i] == DEAD_ONE) && !level[i];
                end else begin
                    PWM_hi[i] <= level[i];
                    PWM_lo[i] <= !level[i];
                end
            end
        end
    end

endmodule
